des_round_controller: RTL and testbench
=======================================

Name: des_round_controller

Overview:
- Iterative sequencer for the DES round datapath (expansion, key XOR, S-boxes 1-8, P-permutation, L/R feedback registers, C/D key registers).
- Accepts one block per start handshake, drives 16 rounds of control (load/feedback select, register enable, key-rotation amount/direction, final no-swap), then holds a done flag until acknowledged.
- Contains no datapath bits; it is a pure control FSM placed beside the round datapath inside the DES engine.

Parameters:
- ROUND_WAIT, 0, extra stall cycles per round (0..3) so a registered S-box/P stage can settle; each round lasts ROUND_WAIT+1 cycles.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_din  in  1  request to process the block currently presented on the datapath inputs
- decrypt_din  in  1  mode: 0 encrypt, 1 decrypt; sampled only on accept
- abort_din  in  1  synchronous abort, returns the controller to IDLE
- start_ready_dout  out  1  controller can accept a block (IDLE only)
- busy_dout  out  1  high in ROUND and DONE
- load_sel_dout  out  1  1 = datapath sources input block/PC1 key; 0 = feedback registers
- round_en_dout  out  1  datapath L/R and C/D registers update this cycle
- round_count_dout  out  4  current round index 0..15
- key_shift_dout  out  2  rotation for this round's subkey: 0, 1 or 2
- key_dir_dout  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
- last_round_dout  out  1  round 15 active: datapath must skip the L/R swap
- done_dout  out  1  result valid on datapath outputs
- done_ack_din  in  1  consumer has taken the result

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, round_count 0, wait counter 0, mode 0. Outputs: start_ready 1; busy, load_sel, round_en, last_round, done, key_dir all 0; key_shift 0.
- States: IDLE, ROUND, DONE.
- IDLE: start_ready=1. Accept = start_din & start_ready. On accept: mode <= decrypt_din, round_count <= 0, wait <= ROUND_WAIT, state -> ROUND.
- ROUND: round_en=1 only when wait==0; otherwise wait decrements. load_sel=1 for all cycles of round 0, else 0. On round_en with round_count<15: round_count+1, wait reloads ROUND_WAIT. On round_en with round_count==15: state -> DONE, round_count holds 15.
- key_shift is combinational from round_count and mode:
  - Encrypt, rounds 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - key_dir = mode. key_shift/key_dir are valid throughout ROUND and 0 outside it.
- last_round = (state==ROUND) & (round_count==15).
- DONE: done=1, busy=1. On done_ack_din -> IDLE next edge. Ack outside DONE is ignored.
- Latency (ROUND_WAIT=W): accept at edge 0; round_en at edges (W+1)*k for k=1..16; done high from the cycle after the 16th round_en; 16*(W+1) cycles in ROUND.
- No back-to-back accept in DONE: start is accepted only one cycle after the ack.
- abort_din has priority over every other transition in every state: next edge -> IDLE, counters cleared. In that same cycle round_en is forced 0 and done is not raised.
- start_din while busy is ignored, not queued. decrypt_din changes mid-operation have no effect.
- Key-rotation sum check (datapath invariant): encrypt totals 28 left; decrypt totals 27 right before the final round.

Decomposition:
- Shared des_pkg: ROUND_LAST=15; state encoding constants (IDLE, ROUND, DONE); 16-entry encrypt shift table; decrypt round-0 override value 0.
- One natural sub-module: des_key_shift_lut (round index + mode -> 2-bit shift), combinational and reused by any pipelined key-schedule variant.
- FSM, round counter and wait counter stay in the top module.

Test Plan:
- Reset, ROUND_WAIT=0: assert reset_n=0 mid-round 7 -> all outputs at reset values immediately (asynchronous); start_ready=1 after release.
- Encrypt, W=0: start at cycle 0 -> round_en high cycles 1..16; key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; load_sel only in cycle 1; last_round only in cycle 16; done from cycle 17.
- Decrypt, W=2: key_dir=1, shift sequence 0,1,2,...,1; each round lasts 3 cycles with round_en on the third; done at cycle 49; toggling decrypt_din mid-run has no effect.
- Done hold: withhold ack 10 cycles -> done stays 1 and start_din is ignored; ack -> IDLE next edge; a new start is accepted one cycle after that.
- Abort at round 9 together with a round_en cycle -> no round_en that cycle; IDLE next edge with round_count 0 and done never asserted; a fresh encrypt then runs to completion.
- Run the controller with the real round datapath on FIPS vector key 133457799BBCDFF1, plaintext 0123456789ABCDEF -> ciphertext 85E813540F0AB405; decrypt recovers the plaintext.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants for the DES round controller: FSM encoding, round bounds
// and the encrypt key-rotation schedule.
package des_pkg;

  localparam logic [3:0] ROUND_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Left-rotation amount applied to C/D before the subkey of each round is drawn.
  localparam logic [1:0] ENC_SHIFT_TABLE [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt starts from the unrotated PC1 key, which already equals K16's C/D.
  localparam logic [1:0] DEC_ROUND0_SHIFT = 2'd0;

endpackage

// File: rtl/des_key_shift_lut.sv
// Round index + mode -> C/D rotation amount for that round's subkey.
module des_key_shift_lut
  import des_pkg::*;
(
  input  logic [3:0] round_idx,
  input  logic       decrypt,
  output logic [1:0] shift
);

  // Right-rotation in decrypt mirrors the encrypt schedule except round 0.
  always_comb begin
    shift = ENC_SHIFT_TABLE[round_idx];
    if (decrypt && (round_idx == 4'd0)) begin
      shift = DEC_ROUND0_SHIFT;
    end
  end

endmodule

// File: rtl/des_round_controller.sv
// Iterative 16-round DES sequencer: accepts a block, steps the round datapath
// and key schedule, then holds done until the consumer acknowledges.
module des_round_controller
  import des_pkg::*;
#(
  parameter int ROUND_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_din,
  input  logic       decrypt_din,
  input  logic       abort_din,
  input  logic       done_ack_din,
  output logic       start_ready_dout,
  output logic       busy_dout,
  output logic       load_sel_dout,
  output logic       round_en_dout,
  output logic [3:0] round_count_dout,
  output logic [1:0] key_shift_dout,
  output logic       key_dir_dout,
  output logic       last_round_dout,
  output logic       done_dout
);

  localparam logic [1:0] WAIT_INIT = 2'(ROUND_WAIT);

  state_t     state, state_nxt;
  logic [3:0] round_cnt, round_cnt_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  logic       mode, mode_nxt;
  logic [1:0] lut_shift;

  des_key_shift_lut u_shift_lut (
    .round_idx (round_cnt),
    .decrypt   (mode),
    .shift     (lut_shift)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      round_cnt <= 4'd0;
      wait_cnt  <= 2'd0;
      mode      <= 1'b0;
    end else begin
      state     <= state_nxt;
      round_cnt <= round_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mode      <= mode_nxt;
    end
  end

  assign round_count_dout = round_cnt;

  always_comb begin
    state_nxt        = state;
    round_cnt_nxt    = round_cnt;
    wait_cnt_nxt     = wait_cnt;
    mode_nxt         = mode;
    start_ready_dout = 1'b0;
    busy_dout        = 1'b0;
    load_sel_dout    = 1'b0;
    round_en_dout    = 1'b0;
    key_shift_dout   = 2'd0;
    key_dir_dout     = 1'b0;
    last_round_dout  = 1'b0;
    done_dout        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        start_ready_dout = 1'b1;
        if (start_din) begin
          state_nxt     = ST_ROUND;
          round_cnt_nxt = 4'd0;
          wait_cnt_nxt  = WAIT_INIT;
          mode_nxt      = decrypt_din;
        end
      end

      ST_ROUND: begin
        busy_dout       = 1'b1;
        load_sel_dout   = (round_cnt == 4'd0);
        last_round_dout = (round_cnt == ROUND_LAST);
        key_shift_dout  = lut_shift;
        key_dir_dout    = mode;
        // The datapath registers advance only on the final cycle of each round.
        if (wait_cnt != 2'd0) begin
          wait_cnt_nxt = wait_cnt - 2'd1;
        end else begin
          round_en_dout = 1'b1;
          if (round_cnt == ROUND_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            round_cnt_nxt = round_cnt + 4'd1;
            wait_cnt_nxt  = WAIT_INIT;
          end
        end
      end

      ST_DONE: begin
        busy_dout = 1'b1;
        done_dout = 1'b1;
        if (done_ack_din) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort wins over every transition and suppresses the pending round update.
    if (abort_din) begin
      state_nxt     = ST_IDLE;
      round_cnt_nxt = 4'd0;
      wait_cnt_nxt  = 2'd0;
      round_en_dout = 1'b0;
    end
  end

endmodule

// File: tb/tb_des_round_controller.sv
// Bench for des_round_controller: ROUND_WAIT=0 and ROUND_WAIT=2 instances plus a
// reference DES round datapath steered only by the controller outputs.
module tb_des_round_controller;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       ld;
    logic       ren;
    logic [3:0] rc;
    logic [1:0] sh;
    logic       dir;
    logic       last;
    logic       done;
  } obs_t;

  localparam logic [63:0] KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] PT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT  = 64'h85E8_1354_0F0A_B405;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, decrypt, abort, ack;
  int   sel;
  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];
  obs_t obs;

  logic       rdy0, busy0, ld0, ren0, dir0, last0, done0;
  logic [3:0] rc0;
  logic [1:0] sh0;
  logic       rdy2, busy2, ld2, ren2, dir2, last2, done2;
  logic [3:0] rc2;
  logic [1:0] sh2;

  des_round_controller #(.ROUND_WAIT(0)) u_w0 (
    .clk(clk), .reset_n(reset_n),
    .start_din(start && sel == 0), .decrypt_din(decrypt),
    .abort_din(abort && sel == 0), .done_ack_din(ack && sel == 0),
    .start_ready_dout(rdy0), .busy_dout(busy0), .load_sel_dout(ld0),
    .round_en_dout(ren0), .round_count_dout(rc0), .key_shift_dout(sh0),
    .key_dir_dout(dir0), .last_round_dout(last0), .done_dout(done0)
  );

  des_round_controller #(.ROUND_WAIT(2)) u_w2 (
    .clk(clk), .reset_n(reset_n),
    .start_din(start && sel == 1), .decrypt_din(decrypt),
    .abort_din(abort && sel == 1), .done_ack_din(ack && sel == 1),
    .start_ready_dout(rdy2), .busy_dout(busy2), .load_sel_dout(ld2),
    .round_en_dout(ren2), .round_count_dout(rc2), .key_shift_dout(sh2),
    .key_dir_dout(dir2), .last_round_dout(last2), .done_dout(done2)
  );

  always_comb begin
    if (sel == 0) obs = {rdy0, busy0, ld0, ren0, rc0, sh0, dir0, last0, done0};
    else          obs = {rdy2, busy2, ld2, ren2, rc2, sh2, dir2, last2, done2};
  end

  // ---------------- reference DES datapath ----------------
  int ENC_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,   19,13,30,6,22,11,4,25};
  logic [63:0] SBOX [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [63:0] do_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] do_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [55:0] do_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] do_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input int n, input logic right);
    if (right) return (x >> n) | (x << (28 - n));
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, y;
    logic [5:0]  six;
    logic [63:0] rowbits;
    int          row, col;
    for (int i = 0; i < 48; i++) e[47-i] = r[31 - ((4*(i/6) + i%6 + 31) % 32)];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six     = e[47-6*b -: 6];
      row     = 2*int'(six[5]) + int'(six[0]);
      col     = int'(six[4:1]);
      rowbits = SBOX[b*4+row];
      s[31-4*b -: 4] = rowbits[63-4*col -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [119:0] dp_step(input logic [63:0] lr, input logic [55:0] cd,
                                           input logic [1:0] sh, input logic dir, input logic last);
    logic [27:0] c, d;
    logic [31:0] f;
    c = rot28(cd[55:28], int'(sh), dir);
    d = rot28(cd[27:0],  int'(sh), dir);
    f = feistel(lr[31:0], do_pc2({c, d}));
    if (last) return {lr[63:32] ^ f, lr[31:0], c, d};
    return {lr[31:0], lr[63:32] ^ f, c, d};
  endfunction

  logic [63:0] dp_block, dp_key, m_lr;
  logic [55:0] m_cd;
  int          rot_sum = 0;

  always @(posedge clk) begin
    if (obs.ren === 1'b1) begin
      if (obs.ld) {m_lr, m_cd} <= dp_step(do_ip(dp_block), do_pc1(dp_key), obs.sh, obs.dir, obs.last);
      else        {m_lr, m_cd} <= dp_step(m_lr, m_cd, obs.sh, obs.dir, obs.last);
      rot_sum <= (obs.ld ? 0 : rot_sum) + int'(obs.sh);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic obs_t idle_o();
    obs_t o;
    o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  // Accept a block and queue the expected per-cycle outputs up to the first done cycle.
  task automatic launch(input int w, input logic dec);
    obs_t e;
    int   k;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 16*(w+1); n++) begin
      k      = n / (w + 1);
      e      = '0;
      e.busy = 1'b1;
      e.ld   = (k == 0);
      e.ren  = ((n % (w + 1)) == w);
      e.rc   = 4'(k);
      e.sh   = (dec && k == 0) ? 2'd0 : 2'(ENC_SH[k]);
      e.dir  = dec;
      e.last = (k == 15);
      exp_q.push_back(e);
    end
    e      = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.rc   = 4'd15;
    exp_q.push_back(e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t e;
    sel = 0;
    tick(); tick();
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL reset_hold: got %h want %h", obs, idle_o()); end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL idle_after_release: got %h want %h", obs, idle_o()); end
    launch(0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_run cycle %0d: got %h want %h", n, obs, e); end
      if (n < 7) tick();
    end
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL reset_async: got %h want %h", obs, idle_o()); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL ready_after_reset: got %h want %h", obs, idle_o()); end
  endtask

  task automatic test_encrypt_w0();
    obs_t e;
    int   n;
    sel = 0; dp_block = PT; dp_key = KEY;
    launch(0, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL enc_w0 cycle %0d: got %h want %h", n, obs, e); end
      if (exp_q.size() > 0) tick();
      n++;
    end
    vectors++;
    if (do_fp(m_lr) !== CT) begin miscompares++; $display("FAIL enc_cipher: got %h want %h", do_fp(m_lr), CT); end
    vectors++;
    if (rot_sum != 28) begin miscompares++; $display("FAIL enc_rot_sum: got %0d want 28", rot_sum); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({obs.rdy, obs.busy, obs.done} !== 3'b100) begin
      miscompares++; $display("FAIL enc_ack_idle: got rdy/busy/done %b want 100", {obs.rdy, obs.busy, obs.done});
    end
  endtask

  task automatic test_decrypt_w2();
    obs_t e;
    int   n;
    sel = 1; dp_block = CT; dp_key = KEY;
    launch(2, 1'b1);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL dec_w2 cycle %0d: got %h want %h", n, obs, e); end
      if (n == 5)  start = 1'b1;
      if (n == 6)  start = 1'b0;
      if (n == 10) decrypt = 1'b0;
      if (n == 20) decrypt = 1'b1;
      if (exp_q.size() > 0) tick();
      n++;
    end
    vectors++;
    if (do_fp(m_lr) !== PT) begin miscompares++; $display("FAIL dec_plain: got %h want %h", do_fp(m_lr), PT); end
    vectors++;
    if (rot_sum != 27) begin miscompares++; $display("FAIL dec_rot_sum: got %0d want 27", rot_sum); end
  endtask

  task automatic test_done_hold();
    obs_t e;
    sel   = 1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({obs.rdy, obs.busy, obs.done, obs.ren} !== 4'b0110) begin
        miscompares++; $display("FAIL done_hold cycle %0d: got rdy/busy/done/ren %b want 0110", i,
                                {obs.rdy, obs.busy, obs.done, obs.ren});
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({obs.rdy, obs.busy, obs.done} !== 3'b100) begin
      miscompares++; $display("FAIL ack_to_idle: got rdy/busy/done %b want 100", {obs.rdy, obs.busy, obs.done});
    end
    tick();
    start = 1'b0;
    e = '0; e.busy = 1'b1; e.ld = 1'b1; e.dir = 1'b1; e.sh = 2'd0;
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL restart_after_ack: got %h want %h", obs, e); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL abort_round0: got %h want %h", obs, idle_o()); end
  endtask

  task automatic test_abort();
    obs_t e;
    int   n;
    sel = 0; dp_block = PT; dp_key = KEY;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if ({obs.rdy, obs.busy, obs.done} !== 3'b100) begin
      miscompares++; $display("FAIL ack_in_idle: got rdy/busy/done %b want 100", {obs.rdy, obs.busy, obs.done});
    end
    launch(0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      if (k == 9) begin
        abort = 1'b1;
        #1;
        e.ren = 1'b0;
      end
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL abort_run cycle %0d: got %h want %h", k, obs, e); end
      tick();
    end
    abort = 1'b0;
    exp_q.delete();
    vectors++;
    if (obs !== idle_o()) begin miscompares++; $display("FAIL abort_to_idle: got %h want %h", obs, idle_o()); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs !== idle_o()) begin miscompares++; $display("FAIL abort_no_done cycle %0d: got %h want %h", i, obs, idle_o()); end
    end
    launch(0, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL post_abort_enc cycle %0d: got %h want %h", n, obs, e); end
      if (exp_q.size() > 0) tick();
      n++;
    end
    vectors++;
    if (do_fp(m_lr) !== CT) begin miscompares++; $display("FAIL post_abort_cipher: got %h want %h", do_fp(m_lr), CT); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0; ack = 1'b0;
    sel = 0; dp_block = '0; dp_key = '0;
    test_reset();
    test_encrypt_w0();
    test_decrypt_w2();
    test_done_hold();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
